addr8s_redundant_sched: RTL

- Time-redundant scheduler that shares one external combinational 8-bit signed adder (9-bit sum, sum[8] = sign/overflow-extended MSB) among N_REQ requesters.
- Each accepted operation is computed twice and the two 9-bit results are compared.
- On a mismatch the operation is retried up to MAX_RETRY times. If it still mismatches, the response carries an error flag.
- Sits between client pipelines and the fault-resilient adder instance, turning per-evaluation fault resilience into detected/corrected results at system level.

---
 rtl/addr8s_sched_pkg.sv | 25 ++
 rtl/addr8s_rr_arb.sv | 37 +++
 rtl/addr8s_redundant_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/addr8s_sched_pkg.sv
// Shared types and constants for the time-redundant adder scheduler.
package addr8s_sched_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PASS1 = 3'd1,
        PASS2 = 3'd2,
        CMP   = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Width needed to hold the values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/addr8s_rr_arb.sv
// Combinational round-robin picker: the first valid requester found when
// searching upward from the pointer, wrapping modulo N_REQ.
module addr8s_rr_arb
    import addr8s_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_reqValid,
    input  logic [IDX_W-1:0] i_rrPtr,
    output logic [N_REQ-1:0] o_grantOh,
    output logic [IDX_W-1:0] o_grantIdx
);

    int               w_cand;
    logic [IDX_W-1:0] w_candIdx;
    logic             w_found;

    // Walk the requesters starting at the pointer and keep the first valid one.
    always_comb begin
        o_grantOh  = '0;
        o_grantIdx = '0;
        w_cand     = 0;
        w_candIdx  = '0;
        w_found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand    = (int'(i_rrPtr) + k) % N_REQ;
            w_candIdx = IDX_W'(w_cand);
            if (!w_found && i_reqValid[w_candIdx]) begin
                w_found               = 1'b1;
                o_grantOh[w_candIdx]  = 1'b1;
                o_grantIdx            = w_candIdx;
            end
        end
    end

endmodule

// File: rtl/addr8s_redundant_sched.sv
// Time-redundant scheduler sharing one external 8-bit signed adder among
// N_REQ requesters. Every operation is evaluated twice and compared; on a
// mismatch it is re-run up to MAX_RETRY more times before being flagged.
// Build option ADDR8S_OPERAND_SWAP_EN: the second pass feeds the adder with
// the operands swapped, so faults tied to one operand position show up.
module addr8s_redundant_sched
    import addr8s_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [SUM_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [OP_W-1:0]       add_a,
    output logic [OP_W-1:0]       add_b,
    input  logic [SUM_W-1:0]      add_sum,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  busy
);

    localparam int IDX_W   = clog2(N_REQ);
    localparam int RETRY_W = clog2(MAX_RETRY + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_grantIdx;
    logic [IDX_W-1:0]   r_rrPtr;
    logic [RETRY_W-1:0] r_retryCnt;
    logic [OP_W-1:0]    r_opA;
    logic [OP_W-1:0]    r_opB;
    logic [OP_W-1:0]    r_addA;
    logic [OP_W-1:0]    r_addB;
    logic [SUM_W-1:0]   r_sum1;
    logic [SUM_W-1:0]   r_sum2;
    logic [SUM_W-1:0]   r_rspData;
    logic               r_rspErr;
    logic [CNT_W-1:0]   r_mismatchCnt;

    logic [N_REQ-1:0]   w_grantOh;
    logic [IDX_W-1:0]   w_grantIdx;
    logic [OP_W-1:0]    w_selA;
    logic [OP_W-1:0]    w_selB;
    logic               w_anyValid;
    logic               w_match;
    logic               w_canRetry;
    logic               w_rspTaken;

    addr8s_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_reqValid (req_valid),
        .i_rrPtr    (r_rrPtr),
        .o_grantOh  (w_grantOh),
        .o_grantIdx (w_grantIdx)
    );

    assign w_anyValid = |req_valid;
    assign w_match    = (r_sum1 == r_sum2);
    assign w_canRetry = (r_retryCnt < RETRY_W'(MAX_RETRY));
    assign w_rspTaken = |(rsp_ready & rsp_valid);

    // Operand mux for the requester the arbiter is currently offering a grant.
    always_comb begin
        w_selA = '0;
        w_selB = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grantIdx == IDX_W'(i)) begin
                w_selA = req_a[i*OP_W +: OP_W];
                w_selB = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Handshake outputs: accept only in IDLE, respond only to the held grant.
    always_comb begin
        req_ready = (r_state == IDLE) ? w_grantOh : '0;
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = (r_state == RESP) && (r_grantIdx == IDX_W'(i));
        end
    end

    // Next-state logic for the accept / two-pass / compare / respond cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = PASS1;
            PASS1:   w_nextState = PASS2;
            PASS2:   w_nextState = CMP;
            CMP: begin
                if (w_match || !w_canRetry) w_nextState = RESP;
                else                        w_nextState = PASS1;
            end
            RESP:    if (w_rspTaken) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Datapath: adder operands are loaded one cycle ahead of the pass using them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grantIdx    <= '0;
            r_rrPtr       <= '0;
            r_retryCnt    <= '0;
            r_opA         <= '0;
            r_opB         <= '0;
            r_addA        <= '0;
            r_addB        <= '0;
            r_sum1        <= '0;
            r_sum2        <= '0;
            r_rspData     <= '0;
            r_rspErr      <= 1'b0;
            r_mismatchCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_grantIdx <= w_grantIdx;
                        r_opA      <= w_selA;
                        r_opB      <= w_selB;
                        r_addA     <= w_selA;
                        r_addB     <= w_selB;
                        r_retryCnt <= '0;
                    end
                end
                PASS1: begin
                    r_sum1 <= add_sum;
`ifdef ADDR8S_OPERAND_SWAP_EN
                    r_addA <= r_opB;
                    r_addB <= r_opA;
`else
                    r_addA <= r_opA;
                    r_addB <= r_opB;
`endif
                end
                PASS2: begin
                    r_sum2 <= add_sum;
                end
                CMP: begin
                    if (w_match) begin
                        r_rspData <= r_sum1;
                        r_rspErr  <= 1'b0;
                    end else begin
                        if (r_mismatchCnt != '1) r_mismatchCnt <= r_mismatchCnt + CNT_W'(1);
                        if (w_canRetry) begin
                            r_retryCnt <= r_retryCnt + RETRY_W'(1);
                            r_addA     <= r_opA;
                            r_addB     <= r_opB;
                        end else begin
                            r_rspData <= r_sum1;
                            r_rspErr  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (w_rspTaken) begin
                        r_rrPtr <= (r_grantIdx == IDX_W'(N_REQ - 1)) ? '0 : r_grantIdx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data     = r_rspData;
    assign rsp_err      = r_rspErr;
    assign add_a        = r_addA;
    assign add_b        = r_addB;
    assign mismatch_cnt = r_mismatchCnt;
    assign busy         = (r_state != IDLE);

endmodule
